// File: rtl/mandelbrot_scheduler.sv
// Frame scheduler: walks the raster, hands pixels to the lowest-index idle engine,
// and collects finished results round-robin into a single valid/ready output register.
module mandelbrot_scheduler #(
  parameter int NUM_ENGINES      = 4,
  parameter int PIXEL_DATA_WIDTH = 32,
  parameter int ITERATIONS_WIDTH = 32,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     frame_start,
  output logic                                     frame_busy,
  output logic                                     frame_done,
  output logic [NUM_ENGINES-1:0]                   eng_start,
  output logic [PIXEL_DATA_WIDTH-1:0]              eng_x0,
  output logic [PIXEL_DATA_WIDTH-1:0]              eng_y0,
  input  logic [NUM_ENGINES-1:0]                   eng_finished,
  input  logic [NUM_ENGINES*ITERATIONS_WIDTH-1:0]  eng_iterations,
  input  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0]  eng_xpixel,
  input  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0]  eng_ypixel,
  output logic [NUM_ENGINES-1:0]                   eng_ack,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [ITERATIONS_WIDTH-1:0]              out_iterations,
  output logic [PIXEL_DATA_WIDTH-1:0]              out_xpixel,
  output logic [PIXEL_DATA_WIDTH-1:0]              out_ypixel
);

  localparam int RRW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [PIXEL_DATA_WIDTH-1:0] LAST_X = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] LAST_Y = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

  logic [1:0]                  state_q, state_d;
  logic [PIXEL_DATA_WIDTH-1:0] px_q, px_d, py_q, py_d;
  logic [NUM_ENGINES-1:0]      busy_q, busy_d;
  logic [RRW-1:0]              rr_q, rr_d;
  logic                        out_valid_q, out_valid_d;
  logic [ITERATIONS_WIDTH-1:0] out_iter_q, out_iter_d;
  logic [PIXEL_DATA_WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d;

  logic [NUM_ENGINES-1:0] start_s, ack_s, cand_s;
  logic                   idle_hit_s, gnt_hit_s, collect_s, can_load_s, done_s;
  logic [RRW-1:0]         gnt_s;

  function automatic logic [RRW-1:0] rr_index(input logic [RRW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_ENGINES) s = s - NUM_ENGINES;
    return RRW'(s);
  endfunction

  // Lowest-index idle engine gets the current raster pixel while dispatching.
  always_comb begin
    start_s    = '0;
    idle_hit_s = 1'b0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (state_q == S_DISPATCH && !busy_q[i] && !idle_hit_s) begin
        start_s[i] = 1'b1;
        idle_hit_s = 1'b1;
      end
    end
  end

  // Round-robin grant among busy engines reporting a result, starting at rr_q.
  always_comb begin
    cand_s     = eng_finished & busy_q;
    can_load_s = !out_valid_q || out_ready;
    gnt_s      = '0;
    gnt_hit_s  = 1'b0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!gnt_hit_s && cand_s[rr_index(rr_q, k)]) begin
        gnt_s     = rr_index(rr_q, k);
        gnt_hit_s = 1'b1;
      end
    end
    collect_s = (state_q == S_DISPATCH || state_q == S_DRAIN) && can_load_s && gnt_hit_s;
    done_s    = (state_q == S_DRAIN) && (busy_q == '0) && can_load_s;
  end

  // Next-state: output register, busy flags, raster walk and frame sequencing.
  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_iter_d  = out_iter_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    ack_s       = '0;
    if (collect_s) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (gnt_s == RRW'(i)) begin
          ack_s[i]   = 1'b1;
          out_iter_d = eng_iterations[i*ITERATIONS_WIDTH +: ITERATIONS_WIDTH];
          out_x_d    = eng_xpixel[i*PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH];
          out_y_d    = eng_ypixel[i*PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH];
        end
      end
      if (gnt_s == RRW'(NUM_ENGINES - 1)) rr_d = '0;
      else rr_d = gnt_s + RRW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    // A flag cleared by an ack this cycle only frees the engine from the next cycle.
    busy_d = (busy_q | start_s) & ~ack_s;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_DISPATCH;
          px_d    = '0;
          py_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DISPATCH: begin
        if (idle_hit_s) begin
          if (px_q == LAST_X) begin
            px_d = '0;
            if (py_q == LAST_Y) state_d = S_DRAIN;
            else py_d = py_q + PIXEL_DATA_WIDTH'(1);
          end else begin
            px_d = px_q + PIXEL_DATA_WIDTH'(1);
          end
        end else begin
          px_d = px_q;
        end
      end
      S_DRAIN: begin
        if (done_s) state_d = S_IDLE;
        else state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      busy_q      <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_iter_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_iter_q  <= out_iter_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign eng_start      = start_s;
  assign eng_x0         = idle_hit_s ? px_q : '0;
  assign eng_y0         = idle_hit_s ? py_q : '0;
  assign eng_ack        = ack_s;
  assign frame_busy     = (state_q != S_IDLE);
  assign frame_done     = done_s;
  assign out_valid      = out_valid_q;
  assign out_iterations = out_iter_q;
  assign out_xpixel     = out_x_q;
  assign out_ypixel     = out_y_q;

endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Self-checking bench: behavioural engine pool plus a rule-level reference model of
// dispatch order, round-robin collection and the output handshake on a 4x2 screen.
module tb_mandelbrot_scheduler;
  localparam int NE = 2, PW = 32, IW = 32, SW = 4, SH = 2, NPIX = SW * SH;

  logic clk = 1'b0;
  logic reset, frame_start, frame_busy, frame_done, out_valid, out_ready;
  logic [NE-1:0] eng_start, eng_finished, eng_ack;
  logic [PW-1:0] eng_x0, eng_y0, out_xpixel, out_ypixel;
  logic [NE*IW-1:0] eng_iterations;
  logic [NE*PW-1:0] eng_xpixel, eng_ypixel;
  logic [IW-1:0] out_iterations;

  always #5 clk = ~clk;

  mandelbrot_scheduler #(.NUM_ENGINES(NE), .PIXEL_DATA_WIDTH(PW), .ITERATIONS_WIDTH(IW),
                         .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_busy(frame_busy),
    .frame_done(frame_done), .eng_start(eng_start), .eng_x0(eng_x0), .eng_y0(eng_y0),
    .eng_finished(eng_finished), .eng_iterations(eng_iterations), .eng_xpixel(eng_xpixel),
    .eng_ypixel(eng_ypixel), .eng_ack(eng_ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_iterations(out_iterations), .out_xpixel(out_xpixel), .out_ypixel(out_ypixel));

  int errors = 0, checks = 0;
  logic e_busy[NE], e_fin[NE];
  int e_cnt[NE], e_delay[NE];
  logic [31:0] e_x[NE], e_y[NE], e_it[NE];
  logic [31:0] ref_iter[NPIX];
  bit seen[NPIX];
  int nres, ndisp, ndone, tb_rr, fc, ready_mode;
  bit frame_active, pend_load, prev_valid, prev_ready;
  logic [31:0] pend_it, pend_x, pend_y, prev_it, prev_x, prev_y;
  logic [NE-1:0] s_start, s_ack;
  logic [31:0] s_x, s_y;
  int out_log[$];

  task automatic drive_engines();
    eng_finished   = {e_fin[1], e_fin[0]};
    eng_iterations = {e_it[1], e_it[0]};
    eng_xpixel     = {e_x[1], e_x[0]};
    eng_ypixel     = {e_y[1], e_y[0]};
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      e_busy[i] = 1'b0; e_fin[i] = 1'b0; e_cnt[i] = 0;
      e_x[i] = 32'd0; e_y[i] = 32'd0; e_it[i] = 32'd0;
    end
    frame_active = 1'b0; pend_load = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
    tb_rr = 0; s_start = '0; s_ack = '0;
    drive_engines();
  endtask

  task automatic tick();
    logic [NE-1:0] exp_start, exp_ack;
    logic exp_done, can_load, all_idle;
    int g, idx;
    @(negedge clk);
    fc++;
    exp_start = '0;
    if (frame_active && ndisp < NPIX)
      for (int i = NE - 1; i >= 0; i--) if (!e_busy[i]) exp_start = 2'b01 << i;
    checks++;
    if (eng_start !== exp_start) begin
      errors++; $display("FAIL start: got %b want %b (fc %0d)", eng_start, exp_start, fc);
    end
    if (eng_start != '0) begin
      checks++;
      if (eng_x0 !== 32'(ndisp % SW) || eng_y0 !== 32'(ndisp / SW)) begin
        errors++; $display("FAIL start_xy: got (%0d,%0d) want (%0d,%0d)", eng_x0, eng_y0, ndisp % SW, ndisp / SW);
      end
    end
    can_load = !out_valid || out_ready;
    exp_ack = '0;
    if (frame_active && can_load)
      for (int k = 0; k < NE; k++) begin
        g = (tb_rr + k) % NE;
        if (exp_ack == '0 && e_fin[g] && e_busy[g]) exp_ack = 2'b01 << g;
      end
    checks++;
    if (eng_ack !== exp_ack) begin
      errors++; $display("FAIL ack: got %b want %b (fc %0d)", eng_ack, exp_ack, fc);
    end
    checks++;
    if (pend_load) begin
      if (out_valid !== 1'b1 || out_iterations !== pend_it || out_xpixel !== pend_x || out_ypixel !== pend_y) begin
        errors++; $display("FAIL load: got v=%b %0d (%0d,%0d) want v=1 %0d (%0d,%0d)", out_valid, out_iterations, out_xpixel, out_ypixel, pend_it, pend_x, pend_y);
      end
    end else if (prev_valid && !prev_ready) begin
      if (out_valid !== 1'b1 || out_iterations !== prev_it || out_xpixel !== prev_x || out_ypixel !== prev_y) begin
        errors++; $display("FAIL hold: got v=%b %0d (%0d,%0d) want v=1 %0d (%0d,%0d)", out_valid, out_iterations, out_xpixel, out_ypixel, prev_it, prev_x, prev_y);
      end
    end else if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drop: got out_valid=%b want 0", out_valid);
    end
    if (out_valid && out_ready) begin
      checks++;
      if (out_xpixel >= 32'(SW) || out_ypixel >= 32'(SH)) begin
        errors++; $display("FAIL range: got (%0d,%0d) want inside %0dx%0d", out_xpixel, out_ypixel, SW, SH);
      end else begin
        idx = int'(out_ypixel) * SW + int'(out_xpixel);
        if (seen[idx]) begin
          errors++; $display("FAIL dup: got pixel %0d again want once", idx);
        end else if (out_iterations !== ref_iter[idx]) begin
          errors++; $display("FAIL iter: got %0d want %0d at pixel %0d", out_iterations, ref_iter[idx], idx);
        end
        if (idx == 6) begin
          checks++;
          if (out_iterations !== 32'd37) begin
            errors++; $display("FAIL iter37: got %0d want 37", out_iterations);
          end
        end
        seen[idx] = 1'b1; nres++; out_log.push_back(idx);
      end
    end
    all_idle = 1'b1;
    for (int i = 0; i < NE; i++) if (e_busy[i]) all_idle = 1'b0;
    exp_done = frame_active && ndisp == NPIX && all_idle && can_load;
    checks++;
    if (frame_done !== exp_done) begin
      errors++; $display("FAIL done: got %b want %b (fc %0d)", frame_done, exp_done, fc);
    end
    checks++;
    if (frame_busy !== frame_active) begin
      errors++; $display("FAIL busy: got %b want %b (fc %0d)", frame_busy, frame_active, fc);
    end
    pend_load = 1'b0;
    for (int i = 0; i < NE; i++)
      if (eng_ack[i]) begin
        pend_load = 1'b1; pend_it = e_it[i]; pend_x = e_x[i]; pend_y = e_y[i]; tb_rr = (i + 1) % NE;
      end
    if (eng_start != '0) ndisp++;
    if (frame_done) begin ndone++; frame_active = 1'b0; end
    prev_valid = out_valid; prev_ready = out_ready;
    prev_it = out_iterations; prev_x = out_xpixel; prev_y = out_ypixel;
    s_start = eng_start; s_ack = eng_ack; s_x = eng_x0; s_y = eng_y0;
    @(posedge clk); #1;
    for (int i = 0; i < NE; i++) if (s_ack[i]) begin e_busy[i] = 1'b0; e_fin[i] = 1'b0; end
    for (int i = 0; i < NE; i++)
      if (s_start[i]) begin
        e_busy[i] = 1'b1; e_fin[i] = 1'b0; e_x[i] = s_x; e_y[i] = s_y;
        e_cnt[i] = (e_delay[i] > 0) ? e_delay[i] : int'($urandom_range(1, 6));
      end
    for (int i = 0; i < NE; i++)
      if (e_busy[i] && !e_fin[i]) begin
        e_cnt[i]--;
        if (e_cnt[i] <= 0) begin
          e_fin[i] = 1'b1;
          e_it[i] = (e_x[i] == 32'd2 && e_y[i] == 32'd1) ? 32'd37 : $urandom;
          idx = int'(e_y[i]) * SW + int'(e_x[i]);
          if (idx >= 0 && idx < NPIX) ref_iter[idx] = e_it[i];
        end
      end
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: out_ready = (fc + 1 >= 6 && fc + 1 < 16) ? 1'b0 : 1'b1;
      default: out_ready = 1'b1;
    endcase
    drive_engines();
  endtask

  task automatic run_frame(input int mode, input int d0, input int d1, input bit repulse);
    ready_mode = mode; e_delay[0] = d0; e_delay[1] = d1;
    nres = 0; ndisp = 0; ndone = 0; out_log.delete();
    for (int i = 0; i < NPIX; i++) seen[i] = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0; frame_active = 1'b1; fc = 0;
    tick();
    checks++;
    if (s_start == '0) begin
      errors++; $display("FAIL first_start: got eng_start=%b want nonzero one cycle after frame_start", s_start);
    end
    for (int n = 0; n < 400 && frame_active; n++) begin
      frame_start = repulse && (n == 3);
      tick();
    end
    frame_start = 1'b0;
    tick();
    checks++;
    if (frame_active || nres != NPIX || ndone != 1 || ndisp != NPIX) begin
      errors++; $display("FAIL frame: got results=%0d done=%0d starts=%0d open=%0d want %0d/1/%0d/0", nres, ndone, ndisp, frame_active, NPIX, NPIX);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b0; out_ready = 1'b1; fc = 0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({eng_start, eng_ack, out_valid, frame_busy, frame_done} !== '0 ||
        {out_iterations, out_xpixel, out_ypixel, eng_x0, eng_y0} !== '0) begin
      errors++; $display("FAIL reset: got start=%b ack=%b v=%b busy=%b done=%b want all 0", eng_start, eng_ack, out_valid, frame_busy, frame_done);
    end
    reset = 1'b0;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    run_frame(0, 4, 3, 1'b0);
    checks++;
    if (out_log.size() < 2 || out_log[0] != 0 || out_log[1] != 1) begin
      errors++; $display("FAIL rr_order: got first outputs %0d,%0d want 0,1", (out_log.size() > 0) ? out_log[0] : -1, (out_log.size() > 1) ? out_log[1] : -1);
    end
  endtask

  task automatic test_reset_mid();
    ready_mode = 1; e_delay[0] = 0; e_delay[1] = 0; ndisp = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0; frame_active = 1'b1; fc = 0;
    for (int n = 0; n < 5; n++) tick();
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({eng_start, eng_ack, out_valid, frame_busy, frame_done} !== '0 ||
        {out_iterations, out_xpixel, out_ypixel, eng_x0, eng_y0} !== '0) begin
      errors++; $display("FAIL reset_mid: got start=%b ack=%b v=%b busy=%b x0=%0d want all 0", eng_start, eng_ack, out_valid, frame_busy, eng_x0);
    end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    tick();
    run_frame(1, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    run_frame(0, 3, 3, 1'b0);
    run_frame(2, 3, 3, 1'b0);
    run_frame(1, 0, 0, 1'b1);
    for (int f = 0; f < 3; f++) run_frame(1, 0, 0, 1'b0);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mandelbrot_scheduler.md
Name: mandelbrot_scheduler

Overview:
Frame-level scheduler that walks the screen raster and dispatches pixel coordinates to a pool of NUM_ENGINES mandelbrot engines. It collects each engine's finished (iterations, xpixel, ypixel) result through a round-robin arbiter. Results go out on a single valid/ready stream to the colour/pixel-write stage. It sits between the frame control registers and the engine array.

Parameters:
NUM_ENGINES, 4, number of engines in the pool (1..16)
PIXEL_DATA_WIDTH, 32, width of pixel coordinate fields
ITERATIONS_WIDTH, 32, width of iteration count
SCREEN_WIDTH, 640, pixels per line
SCREEN_HEIGHT, 480, lines per frame

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
frame_start  in  1  pulse: begin a new frame
frame_busy  out  1  high from accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse when the last result leaves
eng_start  out  NUM_ENGINES  one-hot start pulse to the selected engine
eng_x0  out  PIXEL_DATA_WIDTH  pixel x for the started engine, valid with eng_start
eng_y0  out  PIXEL_DATA_WIDTH  pixel y for the started engine, valid with eng_start
eng_finished  in  NUM_ENGINES  per-engine result-ready level
eng_iterations  in  NUM_ENGINES*ITERATIONS_WIDTH  flattened; engine i at [i*W +: W]
eng_xpixel  in  NUM_ENGINES*PIXEL_DATA_WIDTH  flattened
eng_ypixel  in  NUM_ENGINES*PIXEL_DATA_WIDTH  flattened
eng_ack  out  NUM_ENGINES  one-hot pulse: result of engine i taken
out_valid  out  1  result register holds data
out_ready  in  1  downstream accepts
out_iterations  out  ITERATIONS_WIDTH  result iteration count
out_xpixel  out  PIXEL_DATA_WIDTH  result x
out_ypixel  out  PIXEL_DATA_WIDTH  result y

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0: eng_start, eng_ack, out_valid, frame_busy, frame_done, out data, eng_x0/eng_y0. Busy flags, pixel counters and RR pointer are 0. Reset mid-frame abandons the frame silently.
- State IDLE: frame_start=1 -> DISPATCH next cycle, frame_busy=1, px=py=0. frame_start in any other state is ignored.
- State DISPATCH: each cycle, if any engine has busy=0, pick the lowest-index idle engine k.
  - Pulse eng_start[k] for 1 cycle with eng_x0=px and eng_y0=py. Set busy[k].
  - Advance raster: px+1; at px=SCREEN_WIDTH-1, px->0 and py+1.
  - Dispatching pixel (SCREEN_WIDTH-1, SCREEN_HEIGHT-1) -> DRAIN.
  - At most one dispatch per cycle.
- Collection runs in DISPATCH and DRAIN.
  - Candidate set = eng_finished & busy.
  - The output register can load when out_valid=0, or when out_valid=1 and out_ready=1 (same-cycle replace, no bubble).
  - On load: round-robin grant starting at rr_ptr. Capture that engine's iterations/xpixel/ypixel, pulse eng_ack[g], clear busy[g], set rr_ptr=g+1 mod NUM_ENGINES.
- Busy cleared in cycle t makes the engine dispatchable from cycle t+1, never in t. An engine is never started while busy.
- eng_finished from an engine with busy=0 is ignored (no ack).
- out_valid/out_*: held stable while out_valid=1 and out_ready=0. out_valid drops when consumed with no new load.
- State DRAIN -> IDLE when busy==0 and out_valid==0 (or the last result is consumed this cycle). In that transition, frame_done=1 for one cycle and frame_busy=0 from the next cycle.
- Counters are PIXEL_DATA_WIDTH unsigned. Total results per frame = SCREEN_WIDTH*SCREEN_HEIGHT exactly. Output order is completion order, not raster order.
- Latency: frame_start -> first eng_start = 1 cycle. eng_finished -> out_valid = 1 cycle when the register is free.

Test Plan:
- NUM_ENGINES=2, 4x2 screen, engines respond 3 cycles after start, out_ready=1 -> 8 results with coordinate set {(0..3,0..1)} each exactly once; first eng_start 1 cycle after frame_start; frame_done pulses once; frame_busy falls the following cycle.
- Both engines assert eng_finished in the same cycle, rr_ptr=0 -> engine 0 output first, engine 1 next cycle; rr_ptr ends at 0.
- out_ready held 0 for 10 cycles with a result pending -> out_* stable, out_valid=1, no eng_ack. Other finished engines remain busy and get no new start.
- Engine 1 finishes with iterations=37 at pixel (2,1) -> out_iterations=37, out_xpixel=2, out_ypixel=1; engine 1 restarted no earlier than the cycle after eng_ack[1].
- frame_start re-pulsed mid-frame -> ignored; pixel count stays 8.
- reset asserted mid-DISPATCH (async, between clock edges) -> all outputs 0 immediately. A later frame_start runs a full clean frame from (0,0).
